// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: frames a byte stream as word count, little-endian
// words and an XOR checksum, writes words at ascending addresses, and gates the core reset.
module imem_loader #(
    parameter int MEM_SIZE = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rst_n,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_pos;
    logic [31:0] shreg;
    logic [31:0] word_cnt;
    logic [31:0] idx;
    logic [7:0]  csum;
    logic        acc;
    logic [31:0] word_in;
    logic        last_byte;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready is registered and high exactly while the FSM sits in HDR, DATA or CSUM.
    assign acc       = in_valid && in_ready;
    assign word_in   = {in_data, shreg[31:8]};
    assign last_byte = (byte_pos == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = HDR;
            HDR: begin
                if (acc && last_byte) begin
                    if (word_in > 32'(MEM_SIZE)) state_nxt = ERROR;
                    else if (word_in == 32'd0)   state_nxt = CSUM;
                    else                         state_nxt = DATA;
                end
            end
            DATA: if (acc && last_byte && (idx + 32'd1 == word_cnt)) state_nxt = CSUM;
            CSUM: begin
                if (acc) state_nxt = (in_data == csum) ? DONE : ERROR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            byte_pos  <= 2'd0;
            shreg     <= 32'd0;
            word_cnt  <= 32'd0;
            idx       <= 32'd0;
            csum      <= 8'd0;
        end else begin
            in_ready <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == CSUM);
            mem_we   <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        byte_pos <= 2'd0;
                        shreg    <= 32'd0;
                        word_cnt <= 32'd0;
                        idx      <= 32'd0;
                        csum     <= 8'd0;
                    end
                end
                HDR: begin
                    if (acc) begin
                        shreg    <= word_in;
                        byte_pos <= byte_pos + 2'd1;
                        if (last_byte) word_cnt <= word_in;
                    end
                end
                DATA: begin
                    if (acc) begin
                        shreg    <= word_in;
                        byte_pos <= byte_pos + 2'd1;
                        csum     <= csum ^ in_data;
                        if (last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {idx[29:0], 2'b00};
                            mem_wdata <= word_in;
                            idx       <= idx + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == HDR) || (state == DATA) || (state == CSUM);
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign cpu_rst_n = done;
    assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as stimulus is driven
// and popped by a write monitor; status outputs are checked at fixed points.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, mem_we, busy, done, error, cpu_rst_n;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int write_cnt = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.MEM_SIZE(2000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            write_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 64'hx);
            else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left at a negedge; returns in the cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int tries;
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        tries = 0;
        while (in_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) check("byte_timeout", 64'(tries), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(d));
        check({tag, "_error"}, 64'(error), 64'(e));
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Two-word stream: header 2, words 0x00000013 and 0x00100093, checksum byte last.
    task automatic load_two(input logic [7:0] csum_byte, input int gap_max);
        logic [7:0] s [9];
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        exp_q.push_back({32'h0, 32'h00000013});
        exp_q.push_back({32'h4, 32'h00100093});
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_in_ready", 64'(in_ready), 64'd1);
        check("start_done_clear", 64'({done, error, cpu_rst_n}), 64'd0);
        for (int i = 0; i < 9; i++) send_byte(s[i], gap_max);
        send_byte(8'h00, gap_max);
        send_byte(8'h10, gap_max);
        send_byte(8'h00, gap_max);
        check("last_data_in_csum", 64'({busy, in_ready}), 64'b11);
        send_byte(csum_byte, gap_max);
    endtask

    initial begin
        int w0;
        do_reset();
        check("reset_outs", {60'(0), in_ready, mem_we, busy, done},   64'd0);
        check("reset_flags", {62'(0), error, cpu_rst_n}, 64'd0);
        check("reset_bus", {mem_addr, mem_wdata}, 64'd0);

        // Back-to-back good load, with an explicit write-latency check on word 0.
        exp_q.push_back({32'h0, 32'h00000013});
        exp_q.push_back({32'h4, 32'h00100093});
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("pre_we_low", 64'(mem_we), 64'd0);
        send_byte(8'h00, 0);
        check("we_latency", 64'(mem_we), 64'd1);
        check("we_addr0", 64'(mem_addr), 64'h0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h90, 0);
        check_status("good", 1'b1, 1'b0);
        check("good_writes", 64'(write_cnt), 64'd2);

        // Bad checksum, started from DONE.
        load_two(8'h91, 0);
        check_status("bad_csum", 1'b0, 1'b1);
        check("bad_csum_writes", 64'(write_cnt), 64'd4);

        // Oversize header 2001 from ERROR.
        w0 = write_cnt;
        pulse_start();
        send_byte(8'hD1, 0); send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check_status("oversize", 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("oversize_no_write", 64'(write_cnt - w0), 64'd0);

        // Empty loads.
        pulse_start();
        repeat (5) send_byte(8'h00, 0);
        check_status("empty_ok", 1'b1, 1'b0);
        pulse_start();
        repeat (4) send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        check_status("empty_bad", 1'b0, 1'b1);
        check("empty_no_write", 64'(write_cnt - w0), 64'd0);

        // Random valid gaps.
        load_two(8'h90, 5);
        check_status("gaps", 1'b1, 1'b0);
        check("gaps_q_empty", 64'(exp_q.size()), 64'd0);

        // start during DATA is ignored; start after DONE drops done next cycle.
        exp_q.push_back({32'h0, 32'h78563412});
        pulse_start();
        check("restart_done_drop", 64'({done, cpu_rst_n}), 64'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        pulse_start();
        check("busy_start_ignored", 64'({busy, in_ready}), 64'b11);
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        check_status("one_word", 1'b1, 1'b0);

        // Reset during word 1: only word 0 is written.
        exp_q.push_back({32'h0, 32'h00000013});
        pulse_start();
        send_byte(8'h02, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
        send_byte(8'h13, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
        send_byte(8'h93, 3); send_byte(8'h00, 3);
        w0 = write_cnt;
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = 8'h10;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_outs", {60'(0), in_ready, mem_we, busy, done}, 64'd0);
        check("midrst_flags", {62'(0), error, cpu_rst_n}, 64'd0);
        check("midrst_bus", {mem_addr, mem_wdata}, 64'd0);
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_no_write", 64'(write_cnt - w0), 64'd0);
        check("midrst_idle_ready", 64'({in_ready, busy}), 64'd0);
        check("midrst_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
